// File: rtl/mem_alu_pkg.sv
// Shared types and defaults for the operand-memory / ALU sequencer.
// Optional feature macro: R0_ZERO_EN (address 0 reads as zero and ignores writes).
package mem_alu_pkg;

  localparam int          DATA_W_DEF = 32;
  localparam int          ADDR_W_DEF = 6;
  localparam int unsigned DEPTH_DEF  = 32;
  localparam int          OP_W_DEF   = 4;

  // Sequencer phases: wait for work, read operands, execute, write back.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    EX   = 2'd2,
    WB   = 2'd3
  } state_e;

  // Requester that most recently received the shared write port.
  typedef enum logic {
    HOST  = 1'b0,
    INSTR = 1'b1
  } grant_e;

  // True when an address refers to an implemented memory entry.
  function automatic logic addr_ok(input logic [31:0] addr, input int unsigned depth);
    return addr < depth;
  endfunction

endpackage

// File: rtl/mem_alu_seq_wr_arb2.sv
// Two-requester arbiter with alternating priority on contention.
// Starts with HOST as the last grant so an instruction wins the first tie.
module wr_arb2
  import mem_alu_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic req_host,
  input  logic req_instr,
  output logic gnt_host,
  output logic gnt_instr
);

  grant_e last_grant_q;
  grant_e last_grant_d;

  // Grant decision: a lone requester always wins, a tie goes to the one not served last.
  always_comb begin
    gnt_host  = 1'b0;
    gnt_instr = 1'b0;
    if (en) begin
      if (req_host && req_instr) begin
        if (last_grant_q == HOST) begin
          gnt_instr = 1'b1;
        end else begin
          gnt_host = 1'b1;
        end
      end else begin
        gnt_host  = req_host;
        gnt_instr = req_instr;
      end
    end
    last_grant_d = last_grant_q;
    if (gnt_host) begin
      last_grant_d = HOST;
    end else if (gnt_instr) begin
      last_grant_d = INSTR;
    end
  end

  // Remember who was served most recently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= HOST;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/mem_alu_seq.sv
// Sequencer: fetches two operands from the 2R/1W memory, runs the ALU and
// writes the result back, sharing the write port with a host loader.
// Optional feature macro: R0_ZERO_EN (address 0 hardwired to zero).
module mem_alu_seq
  import mem_alu_pkg::*;
#(
  parameter int          DATA_W = DATA_W_DEF,
  parameter int          ADDR_W = ADDR_W_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF,
  parameter int          OP_W   = OP_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_op,
  input  logic [ADDR_W-1:0] in_rs1,
  input  logic [ADDR_W-1:0] in_rs2,
  input  logic [ADDR_W-1:0] in_rd,
  input  logic              hw_valid,
  output logic              hw_ready,
  input  logic [ADDR_W-1:0] hw_addr,
  input  logic [DATA_W-1:0] hw_data,
  output logic [ADDR_W-1:0] mem_dir_lec,
  output logic [ADDR_W-1:0] mem_dir2_lec,
  output logic [ADDR_W-1:0] mem_dir_es,
  output logic [DATA_W-1:0] mem_dato_es,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_dato1,
  input  logic [DATA_W-1:0] mem_dato2,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_op,
  input  logic [DATA_W-1:0] alu_res,
  output logic              done,
  output logic [DATA_W-1:0] done_data,
  output logic              err,
  output logic              busy
);

`ifdef R0_ZERO_EN
  localparam bit R0_ZERO = 1'b1;
`else
  localparam bit R0_ZERO = 1'b0;
`endif

  // Architectural state
  state_e              state_q, state_d;
  logic [OP_W-1:0]     op_q, op_d;
  logic [ADDR_W-1:0]   rs1_q, rs1_d;
  logic [ADDR_W-1:0]   rs2_q, rs2_d;
  logic [ADDR_W-1:0]   rd_q, rd_d;
  logic [DATA_W-1:0]   opa_q, opa_d;
  logic [DATA_W-1:0]   opb_q, opb_d;
  logic [DATA_W-1:0]   res_q, res_d;
  logic                err_flag_q, err_flag_d;

  // Registered outputs (each is zero outside the state that drives it)
  logic [ADDR_W-1:0]   lec1_q, lec1_d;
  logic [ADDR_W-1:0]   lec2_q, lec2_d;
  logic [DATA_W-1:0]   alu_a_q, alu_a_d;
  logic [DATA_W-1:0]   alu_b_q, alu_b_d;
  logic [OP_W-1:0]     alu_op_q, alu_op_d;
  logic                wb_we_q, wb_we_d;
  logic                wb_err_q, wb_err_d;
  logic [ADDR_W-1:0]   wb_addr_q, wb_addr_d;
  logic [DATA_W-1:0]   wb_data_q, wb_data_d;
  logic                done_q, done_d;
  logic [DATA_W-1:0]   done_data_q, done_data_d;
  logic                busy_q, busy_d;

  // Grant and address qualification
  logic arb_en;
  logic gnt_host, gnt_instr;
  logic rs1_ok, rs2_ok, rd_ok, host_ok;
  logic rs1_zero, rs2_zero, rd_zero, host_zero;

  // Grants are only possible while idle and out of reset, so no output
  // can assert while rst_n is held low.
  assign arb_en = (state_q == IDLE) && rst_n;

  wr_arb2 u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (arb_en),
    .req_host  (hw_valid),
    .req_instr (in_valid),
    .gnt_host  (gnt_host),
    .gnt_instr (gnt_instr)
  );

  // Range checks and hardwired-zero detection for every address in use.
  always_comb begin
    rs1_ok    = addr_ok(32'(rs1_q), DEPTH);
    rs2_ok    = addr_ok(32'(rs2_q), DEPTH);
    rd_ok     = addr_ok(32'(rd_q), DEPTH);
    host_ok   = addr_ok(32'(hw_addr), DEPTH);
    rs1_zero  = !rs1_ok || (R0_ZERO && (rs1_q == '0));
    rs2_zero  = !rs2_ok || (R0_ZERO && (rs2_q == '0));
    rd_zero   = R0_ZERO && (rd_q == '0);
    host_zero = R0_ZERO && (hw_addr == '0);
  end

  // Next-state and datapath capture for the IDLE -> RD -> EX -> WB sequence.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    rs1_d      = rs1_q;
    rs2_d      = rs2_q;
    rd_d       = rd_q;
    opa_d      = opa_q;
    opb_d      = opb_q;
    res_d      = res_q;
    err_flag_d = err_flag_q;
    case (state_q)
      IDLE: begin
        if (gnt_instr) begin
          state_d    = RD;
          op_d       = in_op;
          rs1_d      = in_rs1;
          rs2_d      = in_rs2;
          rd_d       = in_rd;
          err_flag_d = 1'b0;
        end
      end
      RD: begin
        state_d    = EX;
        opa_d      = rs1_zero ? '0 : mem_dato1;
        opb_d      = rs2_zero ? '0 : mem_dato2;
        err_flag_d = err_flag_q || !rs1_ok || !rs2_ok;
      end
      EX: begin
        state_d = WB;
        res_d   = alu_res;
      end
      WB: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Registered outputs are decoded from the upcoming state so they line up
  // with the state they belong to.
  always_comb begin
    lec1_d      = (state_d == RD) ? rs1_d : '0;
    lec2_d      = (state_d == RD) ? rs2_d : '0;
    alu_a_d     = (state_d == EX) ? opa_d : '0;
    alu_b_d     = (state_d == EX) ? opb_d : '0;
    alu_op_d    = (state_d == EX) ? op_q : '0;
    wb_addr_d   = (state_d == WB) ? rd_q : '0;
    wb_data_d   = (state_d == WB) ? res_d : '0;
    wb_we_d     = (state_d == WB) && rd_ok && !err_flag_q && !rd_zero;
    wb_err_d    = (state_d == WB) && (!rd_ok || err_flag_q);
    done_d      = (state_d == WB);
    done_data_d = (state_d == WB) ? res_d : '0;
    busy_d      = (state_d != IDLE);
  end

  // FSM, datapath and output registers; reset aborts any instruction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      op_q        <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rd_q        <= '0;
      opa_q       <= '0;
      opb_q       <= '0;
      res_q       <= '0;
      err_flag_q  <= 1'b0;
      lec1_q      <= '0;
      lec2_q      <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= '0;
      wb_we_q     <= 1'b0;
      wb_err_q    <= 1'b0;
      wb_addr_q   <= '0;
      wb_data_q   <= '0;
      done_q      <= 1'b0;
      done_data_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      rd_q        <= rd_d;
      opa_q       <= opa_d;
      opb_q       <= opb_d;
      res_q       <= res_d;
      err_flag_q  <= err_flag_d;
      lec1_q      <= lec1_d;
      lec2_q      <= lec2_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_op_q    <= alu_op_d;
      wb_we_q     <= wb_we_d;
      wb_err_q    <= wb_err_d;
      wb_addr_q   <= wb_addr_d;
      wb_data_q   <= wb_data_d;
      done_q      <= done_d;
      done_data_q <= done_data_d;
      busy_q      <= busy_d;
    end
  end

  // Shared write port: a host grant only happens in IDLE, write-back only in
  // WB, so the two sources never overlap and nothing writes during RD.
  always_comb begin
    in_ready     = gnt_instr;
    hw_ready     = gnt_host;
    mem_we       = (gnt_host && host_ok && !host_zero) || wb_we_q;
    mem_dir_es   = gnt_host ? hw_addr : wb_addr_q;
    mem_dato_es  = gnt_host ? hw_data : wb_data_q;
    err          = (gnt_host && !host_ok) || wb_err_q;
    mem_dir_lec  = lec1_q;
    mem_dir2_lec = lec2_q;
    alu_a        = alu_a_q;
    alu_b        = alu_b_q;
    alu_op       = alu_op_q;
    done         = done_q;
    done_data    = done_data_q;
    busy         = busy_q;
  end

endmodule
